// File: rtl/alu_pkg.sv
// Shared opcode and flag types for the execute-stage ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic Z;
        logic C;
        logic V;
        logic S;
    } alu_flags_t;

    function automatic alu_flags_t pack_flags(input logic z, input logic c,
                                              input logic v, input logic s);
        alu_flags_t f;
        f.Z = z;
        f.C = c;
        f.V = v;
        f.S = s;
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder: a + (b ^ {sub}) + sub, with carry-out and signed overflow.
module alu_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_total;

    assign w_b_eff = i_b ^ {WIDTH{i_sub}};
    assign w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum   = w_total[WIDTH-1:0];
    assign o_carry = w_total[WIDTH];

    // Overflow uses the operand MSBs as the adder sees them, so SUB needs no special case.
    assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_total[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_reg.sv
// Registered ALU: op mux and flag generation feeding one result/flags register stage.
module alu_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             S
);

    alu_op_e          w_op;
    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_next_result;
    logic             w_next_c;
    logic             w_next_v;
    alu_flags_t       w_next_flags;

    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    assign w_op  = alu_op_e'(select);
    assign w_sub = (w_op == ALU_SUB);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a     (a),
        .i_b     (b),
        .i_sub   (w_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry),
        .o_ovf   (w_ovf)
    );

    // Select next result and arithmetic flags; logic ops clear C and V.
    always_comb begin
        w_next_result = w_sum;
        w_next_c      = w_carry;
        w_next_v      = w_ovf;
        case (w_op)
            ALU_ADD, ALU_SUB: begin
                w_next_result = w_sum;
                w_next_c      = w_carry;
                w_next_v      = w_ovf;
            end
            ALU_AND: begin
                w_next_result = a & b;
                w_next_c      = 1'b0;
                w_next_v      = 1'b0;
            end
            ALU_OR: begin
                w_next_result = a | b;
                w_next_c      = 1'b0;
                w_next_v      = 1'b0;
            end
            default: begin
                w_next_result = w_sum;
                w_next_c      = w_carry;
                w_next_v      = w_ovf;
            end
        endcase
    end

    // Zero and sign derive from the same next-result value as C and V.
    always_comb begin
        w_next_flags = pack_flags((w_next_result == {WIDTH{1'b0}}), w_next_c,
                                  w_next_v, w_next_result[WIDTH-1]);
    end

    // Result and all four flags load together so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {WIDTH{1'b0}};
            r_flags  <= pack_flags(1'b0, 1'b0, 1'b0, 1'b0);
        end else if (en) begin
            r_result <= w_next_result;
            r_flags  <= w_next_flags;
        end
    end

    assign result = r_result;
    assign Z      = r_flags.Z;
    assign C      = r_flags.C;
    assign V      = r_flags.V;
    assign S      = r_flags.S;

endmodule

// File: tb/tb_alu_reg.sv
// Self-checking bench for alu_reg: directed cases plus randomized traffic against an arithmetic model.
module tb_alu_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] select;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] result;
    logic       Z, C, V, S;

    int n_vec;
    int n_err;

    alu_reg #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .select (select),
        .a      (a),
        .b      (b),
        .result (result),
        .Z      (Z),
        .C      (C),
        .V      (V),
        .S      (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {result, Z, C, V, S} using plain integer arithmetic.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        int ux, uy, sx, sy, full, sres;
        logic [3:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 8) ? ux - 16 : ux;
        sy = (uy >= 8) ? uy - 16 : uy;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                full = ux + uy;
                r    = full[3:0];
                c    = (full > 15);
                sres = sx + sy;
                v    = (sres > 7) || (sres < -8);
            end
            2'b01: begin
                full = ux - uy;
                r    = full[3:0];
                c    = (ux >= uy);
                sres = sx - sy;
                v    = (sres > 7) || (sres < -8);
            end
            2'b10:   r = x & y;
            default: r = x | y;
        endcase
        return {r, (r == 4'b0000), c, v, r[3]};
    endfunction

    function automatic logic [7:0] observed();
        return {result, Z, C, V, S};
    endfunction

    task automatic drive(input logic e, input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        en     = e;
        select = op;
        a      = x;
        b      = y;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b11, 4'b1010, 4'b0101);
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (observed() !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", observed(), 8'h00);
        end
        drive(1'b1, 2'b00, 4'b0111, 4'b0111);
        @(posedge clk); #1;
        n_vec++;
        if (observed() !== 8'h00) begin
            n_err++;
            $display("FAIL reset_hold: got %b want %b", observed(), 8'h00);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        en     = 1'b1;
        select = 2'b00;
        a      = 4'b0000;
        b      = 4'b0000;
        @(posedge clk); #1;
        n_vec++;
        if (observed() !== 8'b0000_1000) begin
            n_err++;
            $display("FAIL reset_first_add: got %b want %b", observed(), 8'b0000_1000);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6];
        logic [3:0]  xs  [6];
        logic [3:0]  ys  [6];
        logic [7:0]  exp [6];
        ops = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
        xs  = '{4'b1010, 4'b0111, 4'b1010, 4'b0001, 4'b1010, 4'b1010};
        ys  = '{4'b0110, 4'b0111, 4'b0110, 4'b0100, 4'b0110, 4'b0110};
        exp = '{8'b0000_1100, 8'b1110_0011, 8'b0100_0110,
                8'b1101_0001, 8'b0010_0000, 8'b1110_0001};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], xs[i], ys[i]);
            @(posedge clk); #1;
            n_vec++;
            if (observed() !== exp[i]) begin
                n_err++;
                $display("FAIL directed_%0d op=%b a=%b b=%b: got %b want %b",
                         i, ops[i], xs[i], ys[i], observed(), exp[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] held;
        held = 8'b1110_0001;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 4'b0111, 4'b0111);
            @(posedge clk); #1;
            n_vec++;
            if (observed() !== held) begin
                n_err++;
                $display("FAIL enable_hold_%0d: got %b want %b", i, observed(), held);
            end
        end
        drive(1'b1, 2'b00, 4'b0111, 4'b0111);
        #1;
        n_vec++;
        if (observed() !== held) begin
            n_err++;
            $display("FAIL enable_before_edge: got %b want %b", observed(), held);
        end
        @(posedge clk); #1;
        n_vec++;
        if (observed() !== 8'b1110_0011) begin
            n_err++;
            $display("FAIL enable_after_edge: got %b want %b", observed(), 8'b1110_0011);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [3:0] x, y;
        logic [7:0] exp;
        for (int i = 0; i < 64; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = 4'($urandom_range(0, 15));
            y  = 4'($urandom_range(0, 15));
            exp = model(op, x, y);
            drive(1'b1, op, x, y);
            @(posedge clk); #1;
            n_vec++;
            if (observed() !== exp) begin
                n_err++;
                $display("FAIL b2b_%0d op=%b a=%b b=%b: got %b want %b", i, op, x, y, observed(), exp);
            end
        end
    endtask

    task automatic test_random_enable();
        logic [1:0] op;
        logic [3:0] x, y;
        logic       e;
        logic [7:0] state;
        state = observed();
        for (int i = 0; i < 128; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = 4'($urandom_range(0, 15));
            y  = 4'($urandom_range(0, 15));
            e  = 1'($urandom_range(0, 1));
            if (e) state = model(op, x, y);
            drive(e, op, x, y);
            @(posedge clk); #1;
            n_vec++;
            if (observed() !== state) begin
                n_err++;
                $display("FAIL rand_en_%0d en=%b op=%b a=%b b=%b: got %b want %b",
                         i, e, op, x, y, observed(), state);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        select = 2'b00;
        a      = 4'b0000;
        b      = 4'b0000;
        #12;
        n_vec++;
        if (observed() !== 8'h00) begin
            n_err++;
            $display("FAIL reset_initial: got %b want %b", observed(), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_enable();
        test_back_to_back();
        test_random_enable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- Registered 4-bit (parameterisable) arithmetic/logic unit with status flags Z, C, V, S.
- Computes add, subtract, AND or OR of operands a and b, selected by a 2-bit opcode.
- Result and flags are captured in output registers one clock after the operands are sampled.
- Used as the execute-stage ALU of the team's small datapath; flags feed the branch/condition logic.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; when high, result and flags registers load on the clock edge
- select  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- result  output  WIDTH  registered result
- Z  output  1  registered zero flag
- C  output  1  registered carry flag
- V  output  1  registered signed-overflow flag
- S  output  1  registered sign flag

Behaviour:
- Reset: rst_n low asynchronously forces result=0, Z=0, C=0, V=0, S=0, regardless of clk.
  - Reset asserted mid-operation discards any pending capture.
  - The first capture happens on the first rising edge with rst_n high and en high.
- Latency: one cycle.
  - Inputs are sampled at rising edge N when en=1; outputs reflect them immediately after edge N.
  - en=0 holds all outputs unchanged.
- Arithmetic uses one shared (WIDTH+1)-bit adder computing a + (b XOR {WIDTH{sub}}) + sub, where sub = (select==01).
  - ADD: result = (a+b) mod 2^WIDTH; C = carry-out bit WIDTH.
  - SUB: result = (a-b) mod 2^WIDTH; C = carry-out of a + ~b + 1, so C=1 means no borrow (a >= b unsigned).
  - V (ADD/SUB) = signed overflow: the operand MSBs as seen by the adder (a[MSB], b'[MSB]) are equal and differ from result[MSB].
- AND / OR: result = a&b or a|b; C=0 and V=0.
- For all ops:
  - Z = (result == 0).
  - S = result[WIDTH-1].
- Flags are computed combinationally from the same next-result value and registered together with result; they are never partially updated.
- Opcode encoding is exhaustive; there is no illegal-opcode case.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [1:0] alu_op_e {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11}.
  - Flag-vector typedef struct packed {Z, C, V, S} alu_flags_t.
- One sub-module, alu_addsub: combinational WIDTH-bit add/subtract with carry-out and overflow outputs.
- alu_reg contains the op mux, flag generation and output registers.

Test Plan:
- Reset: rst_n low with arbitrary inputs, including low mid-cycle -> all outputs 0 immediately. Release, en=1, ADD a=0000 b=0000 -> result 0000, Z=1, C=0, V=0, S=0 after the next edge.
- ADD:
  - a=1010 b=0110 -> result 0000, Z=1, C=1, V=0, S=0.
  - a=0111 b=0111 -> result 1110, Z=0, C=0, V=1, S=1.
- SUB:
  - a=1010 b=0110 -> result 0100, Z=0, C=1, V=1, S=0.
  - a=0001 b=0100 -> result 1101, Z=0, C=0, V=0, S=1.
- Logic, a=1010 b=0110:
  - AND -> result 0010, Z=0, C=0, V=0, S=0.
  - OR -> result 1110, Z=0, C=0, V=0, S=1.
- Enable/latency:
  - Apply ADD 0111+0111 with en=0 -> outputs hold their previous values.
  - Raise en -> new values appear exactly one edge later.
  - Back-to-back operations with en=1 each cycle -> each result appears one cycle after its operands, with no bubbles.
